// File: rtl/pwm_ramp_sequencer.sv
// Soft-start PWM duty sequencer: free-running period counter and comparator whose
// duty code ramps one step at a time toward a requested code, changing only at wraps.
//
// state   | meaning
// IDLE    | disabled; counter, duty and pulse held at 0
// HOLD    | running at a steady duty code equal to the target
// RAMP_UP | raising duty by one code every STEP_PERIODS wraps
// RAMP_DN | lowering duty by one code every STEP_PERIODS wraps
module pwm_ramp_sequencer #(
    parameter int CBITS        = 17,
    parameter int STEP_PERIODS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [3:0] target_duty,
    input  logic       target_valid,
    output logic       pulse,
    output logic       period_tick,
    output logic [3:0] cur_duty,
    output logic       busy
);

    localparam int SBITS = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [SBITS-1:0] STEP_LAST = SBITS'(STEP_PERIODS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RAMP_UP = 2'd2,
        RAMP_DN = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CBITS-1:0] cnt, cnt_nxt, thr;
    logic [3:0]       target_q, duty_nxt;
    logic [SBITS-1:0] step_cnt, step_nxt;
    logic             wrap, running, below;

    assign thr     = {1'b0, cur_duty, 1'b1, {(CBITS-6){1'b0}}};
    assign wrap    = (cnt == '1);
    assign running = enable && (state != IDLE);
    assign below   = (cur_duty < target_q);
    assign busy    = (state == RAMP_UP) || (state == RAMP_DN);

    always_comb begin
        state_nxt = state;
        duty_nxt  = cur_duty;
        step_nxt  = step_cnt;
        cnt_nxt   = running ? cnt + 1'b1 : '0;
        if (!enable) begin
            state_nxt = IDLE;
            duty_nxt  = 4'd0;
            step_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = HOLD;
                    duty_nxt  = 4'd0;
                    step_nxt  = '0;
                end
                HOLD: begin
                    if (cur_duty != target_q) begin
                        state_nxt = below ? RAMP_UP : RAMP_DN;
                        step_nxt  = '0;
                    end
                end
                RAMP_UP, RAMP_DN: begin
                    // Direction is re-judged at every wrap so a step never overshoots a new target
                    if (wrap) begin
                        if (cur_duty == target_q) begin
                            state_nxt = HOLD;
                            step_nxt  = '0;
                        end else if ((state == RAMP_UP) != below) begin
                            state_nxt = below ? RAMP_UP : RAMP_DN;
                        end else if (step_cnt == STEP_LAST) begin
                            step_nxt = '0;
                            duty_nxt = below ? cur_duty + 4'd1 : cur_duty - 4'd1;
                            if (duty_nxt == target_q) begin
                                state_nxt = HOLD;
                            end
                        end else begin
                            step_nxt = step_cnt + 1'b1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            cur_duty    <= 4'd0;
            step_cnt    <= '0;
            target_q    <= 4'd0;
            pulse       <= 1'b0;
            period_tick <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            cur_duty    <= duty_nxt;
            step_cnt    <= step_nxt;
            if (target_valid) begin
                target_q <= target_duty;
            end
            pulse       <= running && (cnt < thr);
            period_tick <= running && wrap;
        end
    end

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Self-checking bench for pwm_ramp_sequencer: directed soft-start scenarios plus random
// target/enable traffic, compared every cycle against a behavioural duty-ramp model.
module tb_pwm_ramp_sequencer;

    localparam int CB  = 8;
    localparam int SP  = 4;
    localparam int PER = 1 << CB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] target_duty = 4'd0;
    logic       target_valid = 1'b0;
    logic       pulse, period_tick, busy;
    logic [3:0] cur_duty;

    int n_checks = 0;
    int n_fail   = 0;

    pwm_ramp_sequencer #(.CBITS(CB), .STEP_PERIODS(SP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .target_duty  (target_duty),
        .target_valid (target_valid),
        .pulse        (pulse),
        .period_tick  (period_tick),
        .cur_duty     (cur_duty),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Reference: running flag, duty code, ramp direction (-1/0/+1) and periods spent on a code
    int m_cnt = 0, m_duty = 0, m_target = 0, m_dir = 0, m_steps = 0;
    int m_run = 0, m_pulse = 0, m_tick = 0;

    function automatic int sgn(int v);
        return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
    endfunction

    task automatic model_step();
        int tgt, want;
        bit wrap;
        tgt = m_target;
        if (target_valid) m_target = target_duty;
        if (!enable || !m_run) begin
            m_run   = enable ? 1 : 0;
            m_cnt   = 0;
            m_duty  = 0;
            m_dir   = 0;
            m_steps = 0;
            m_pulse = 0;
            m_tick  = 0;
        end else begin
            wrap    = (m_cnt == PER - 1);
            m_pulse = (m_cnt < m_duty * (PER / 32) + PER / 64) ? 1 : 0;
            m_tick  = wrap ? 1 : 0;
            want    = sgn(tgt - m_duty);
            if (m_dir == 0) begin
                if (want != 0) begin
                    m_dir   = want;
                    m_steps = 0;
                end
            end else if (wrap) begin
                if (want == 0) begin
                    m_dir   = 0;
                    m_steps = 0;
                end else if (want != m_dir) begin
                    m_dir = want;
                end else if (m_steps == SP - 1) begin
                    m_duty  = m_duty + m_dir;
                    m_steps = 0;
                    if (m_duty == tgt) m_dir = 0;
                end else begin
                    m_steps++;
                end
            end
            m_cnt = (m_cnt + 1) % PER;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_run = 0; m_cnt = 0; m_duty = 0; m_target = 0;
            m_dir = 0; m_steps = 0; m_pulse = 0; m_tick = 0;
        end else begin
            model_step();
        end
    end

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("pulse", pulse, m_pulse);
            check("period_tick", period_tick, m_tick);
            check("cur_duty", cur_duty, m_duty);
            check("busy", busy, (m_dir != 0) ? 1 : 0);
        end
    end

    task automatic strobe(int v);
        @(negedge clk);
        target_duty  = 4'(v);
        target_valid = 1'b1;
        @(negedge clk);
        target_valid = 1'b0;
    endtask

    task automatic wait_tick(int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (period_tick !== 1'b1 && n < budget);
        if (period_tick !== 1'b1) check("tick_timeout", 0, 1);
    endtask

    task automatic wait_duty(int v, bit need_idle, int budget);
        int n;
        n = 0;
        while (!(cur_duty == v && (!need_idle || !busy)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!(cur_duty == v && (!need_idle || !busy))) check("wait_duty_timeout", cur_duty, v);
    endtask

    // Call on a tick cycle; counts pulse-high cycles and ticks over one full period
    task automatic measure(output int hi, output int ticks);
        hi = 0;
        ticks = 0;
        repeat (PER) begin
            @(negedge clk);
            hi    += (pulse === 1'b1) ? 1 : 0;
            ticks += (period_tick === 1'b1) ? 1 : 0;
        end
    endtask

    localparam int RAMP_BUDGET = PER * SP * 17;

    initial begin
        int hi, ticks, maxd, n, r;

        repeat (3) @(negedge clk);
        check("reset_pulse", pulse, 0);
        check("reset_tick", period_tick, 0);
        check("reset_duty", cur_duty, 0);
        check("reset_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;

        // Soft start with no target: steady code 0, threshold 4
        wait_tick(PER + 4);
        measure(hi, ticks);
        check("hold0_width", hi, 4);
        check("hold0_ticks", ticks, 1);
        check("hold0_busy", busy, 0);
        check("hold0_duty", cur_duty, 0);

        strobe(7);
        repeat (2) @(negedge clk);
        check("ramp7_busy", busy, 1);
        wait_duty(7, 1'b1, RAMP_BUDGET);
        wait_tick(PER + 4);
        measure(hi, ticks);
        check("duty7_width", hi, 60);

        // Ramp down 7 -> 5: one code per four wraps
        strobe(5);
        repeat (4) wait_tick(PER + 4);
        check("dn_after4_duty", cur_duty, 6);
        measure(hi, ticks);
        check("duty6_width", hi, 52);
        repeat (3) wait_tick(PER + 4);
        check("dn_after8_duty", cur_duty, 5);
        check("dn_after8_busy", busy, 0);
        measure(hi, ticks);
        check("duty5_width", hi, 44);

        // Drop enable mid-ramp, then restart from 0 toward the retained target
        strobe(15);
        wait_duty(9, 1'b0, RAMP_BUDGET);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("dis_pulse", pulse, 0);
        check("dis_duty", cur_duty, 0);
        check("dis_busy", busy, 0);
        enable = 1'b1;
        wait_duty(1, 1'b0, RAMP_BUDGET);
        check("restart_busy", busy, 1);

        // Reverse direction mid-ramp at code 4
        wait_duty(4, 1'b0, RAMP_BUDGET);
        strobe(2);
        maxd = 0;
        n = 0;
        while (!(cur_duty == 2 && !busy) && n < RAMP_BUDGET) begin
            @(negedge clk);
            if (cur_duty > maxd) maxd = cur_duty;
            n++;
        end
        check("rev_max_le5", (maxd <= 5) ? 1 : 0, 1);
        check("rev_final", cur_duty, 2);

        // Random traffic, including strobes that coincide with a wrap
        for (int i = 0; i < 50; i++) begin
            repeat ($urandom_range(1, 700)) @(negedge clk);
            r = $urandom_range(0, 9);
            if (r < 6) begin
                strobe($urandom_range(0, 15));
            end else if (r < 8) begin
                enable = 1'b0;
                repeat ($urandom_range(1, 5)) @(negedge clk);
                enable = 1'b1;
            end else begin
                wait_tick(PER + 8);
                repeat (PER - 1) @(negedge clk);
                target_duty  = 4'($urandom_range(0, 15));
                target_valid = 1'b1;
                @(negedge clk);
                target_valid = 1'b0;
            end
        end

        // Asynchronous reset while pulse is high
        wait_tick(PER + 8);
        @(negedge clk);
        check("pre_rst_pulse", pulse, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_pulse", pulse, 0);
        check("async_duty", cur_duty, 0);
        check("async_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_tick(PER + 8);
        wait_tick(PER + 8);
        measure(hi, ticks);
        check("post_rst_width", hi, 4);
        check("post_rst_duty", cur_duty, 0);
        check("post_rst_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
